// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock/alarm settings controller: state codes,
// field widths, field limits and wrap-around increment helpers.
package clock_set_ctrl_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_TH  = 3'd1,
        ST_SET_TM  = 3'd2,
        ST_SET_AH  = 3'd3,
        ST_SET_AM  = 3'd4,
        ST_SET_AEN = 3'd5
    } state_t;

    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_MAX) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, ms-tick stability counter and rising-edge press pulse.
// With CLKSET_AUTOREPEAT_EN defined it also exports a "still held" level for auto-repeat.
module btn_debounce #(
    parameter int unsigned DEB_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
`ifdef CLKSET_AUTOREPEAT_EN
    output logic held,
`endif
    output logic press
);

    localparam int unsigned DEB_W = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;

    logic [1:0]       sync_q;
    logic             level;
    logic             level_d;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_d <= level;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == DEB_W'(DEB_MS - 1)) begin
                    level <= sync_q[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_d;

`ifdef CLKSET_AUTOREPEAT_EN
    // Release is seen on the synchronised input before debounce confirms it,
    // so a queued repeat is not delivered after the button has let go.
    assign held = level & sync_q[1];
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Settings controller: debounced buttons drive a set-mode FSM that edits time and alarm fields.
// Optional feature macro: CLKSET_AUTOREPEAT_EN (auto-repeat of a held increment button).
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned DEB_MS          = 20,
    parameter int unsigned TIMEOUT_S       = 30,
    parameter int unsigned HOLD_MS         = 1000,
    parameter int unsigned REPEAT_MS       = 250,
    parameter int unsigned INIT_ALARM_HOUR = 7,
    parameter int unsigned INIT_ALARM_MIN  = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    output logic              time_load,
    output logic [HOUR_W-1:0] time_hour,
    output logic [MIN_W-1:0]  time_min,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic              alarm_en,
    output logic [2:0]        mode
);

    localparam int unsigned TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TO_MS    = TIMEOUT_S * 1000;
    localparam int unsigned TO_W     = $clog2(TO_MS + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              mode_ev;
    logic              inc_press;
    logic              inc_ev;
    logic              any_ev;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout;
    state_t            state;
    state_t            state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

`ifdef CLKSET_AUTOREPEAT_EN
    logic inc_held;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_mode), .held(), .press(mode_ev)
    );
    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_inc), .held(inc_held), .press(inc_press)
    );

    localparam int unsigned RPT_W = $clog2(HOLD_MS + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_q;
    logic             rpt_clr;

    // After the first repeat the counter is preloaded so later repeats come every REPEAT_MS.
    assign rpt_clr = ~inc_held | inc_press | mode_ev | (state_nxt != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b0;
        end else if (rpt_clr) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b0;
        end else if (tick) begin
            if (rpt_cnt == RPT_W'(HOLD_MS - 1)) begin
                rpt_q   <= 1'b1;
                rpt_cnt <= RPT_W'(HOLD_MS - REPEAT_MS);
            end else begin
                rpt_q   <= 1'b0;
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else begin
            rpt_q <= 1'b0;
        end
    end

    assign inc_ev = inc_press | (rpt_q & inc_held);
`else
    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_mode), .press(mode_ev)
    );
    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_inc), .press(inc_press)
    );

    assign inc_ev = inc_press;
`endif

    assign any_ev  = mode_ev | inc_ev;
    assign timeout = (state != ST_RUN) && tick && !any_ev && (to_cnt == TO_W'(TO_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          to_cnt <= '0;
        else if (state == ST_RUN || any_ev) to_cnt <= '0;
        else if (tick)                       to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mode_ev) begin
            case (state)
                ST_RUN:     state_nxt = ST_SET_TH;
                ST_SET_TH:  state_nxt = ST_SET_TM;
                ST_SET_TM:  state_nxt = ST_SET_AH;
                ST_SET_AH:  state_nxt = ST_SET_AM;
                ST_SET_AM:  state_nxt = ST_SET_AEN;
                default:    state_nxt = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nxt = ST_RUN;
        end
    end

    assign mode = state;

    // A mode press in the same cycle as an increment takes priority; the increment is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_load  <= 1'b0;
            time_hour  <= '0;
            time_min   <= '0;
            alarm_hour <= HOUR_W'(INIT_ALARM_HOUR);
            alarm_min  <= MIN_W'(INIT_ALARM_MIN);
            alarm_en   <= 1'b1;
        end else begin
            time_load <= 1'b0;
            if (mode_ev) begin
                if (state == ST_RUN) begin
                    time_hour <= cur_hour;
                    time_min  <= cur_min;
                end
                if (state == ST_SET_TM) time_load <= 1'b1;
            end else if (inc_ev) begin
                case (state)
                    ST_SET_TH:  time_hour  <= hour_inc(time_hour);
                    ST_SET_TM:  time_min   <= min_inc(time_min);
                    ST_SET_AH:  alarm_hour <= hour_inc(alarm_hour);
                    ST_SET_AM:  alarm_min  <= min_inc(alarm_min);
                    ST_SET_AEN: alarm_en   <= ~alarm_en;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with 1 ms = 1 clk; checks reset, debounce,
// time/alarm editing, wrap-around, timeout, button collision and increment repeat.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic       time_load;
    logic [4:0] time_hour;
    logic [5:0] time_min;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    logic [4:0] ld_h = '0;
    logic [5:0] ld_m = '0;

    clock_set_ctrl #(
        .CLK_FREQ(1000), .DEB_MS(2), .TIMEOUT_S(1), .HOLD_MS(5), .REPEAT_MS(2),
        .INIT_ALARM_HOUR(7), .INIT_ALARM_MIN(30)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour(cur_hour), .cur_min(cur_min), .time_load(time_load),
        .time_hour(time_hour), .time_min(time_min), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_en(alarm_en), .mode(mode)
    );

    always #5 clk = ~clk;

    // Every cycle with time_load high is counted, so a stretched strobe shows up as extra loads.
    always @(negedge clk) begin
        if (time_load === 1'b1) begin
            load_cnt = load_cnt + 1;
            ld_h = time_hour;
            ld_m = time_min;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic press(input logic m, input logic i, input int hold_cyc);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (hold_cyc) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_load", time_load, 0);
        check("rst_th", time_hour, 0);
        check("rst_tm", time_min, 0);
        check("rst_ah", alarm_hour, 7);
        check("rst_am", alarm_min, 30);
        check("rst_aen", alarm_en, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Bouncing mode button, then stable high: a single step RUN -> SET_TH with copy of live time
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            btn_mode = ~btn_mode;
        end
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_mode", mode, 1);
        check("copy_th", time_hour, 23);
        check("copy_tm", time_min, 59);

        press(1'b0, 1'b1, 6);
        check("th_wrap", time_hour, 0);
        press(1'b1, 1'b0, 6);
        check("mode_tm", mode, 2);
        press(1'b0, 1'b1, 6);
        check("tm_wrap", time_min, 0);
        check("no_load_yet", load_cnt, 0);
        press(1'b1, 1'b0, 6);
        check("load_once", load_cnt, 1);
        check("load_h", ld_h, 0);
        check("load_m", ld_m, 0);
        check("mode_ah", mode, 3);
        check("load_low", time_load, 0);

        // Alarm editing: 7 -> 9 hours, 30 + 31 minutes wraps to 1, enable toggles off
        press(1'b0, 1'b1, 6);
        press(1'b0, 1'b1, 6);
        check("ah_9", alarm_hour, 9);
        press(1'b1, 1'b0, 6);
        check("mode_am", mode, 4);
        for (int k = 0; k < 31; k++) press(1'b0, 1'b1, 6);
        check("am_1", alarm_min, 1);
        check("ah_kept", alarm_hour, 9);
        press(1'b1, 1'b0, 6);
        check("mode_aen", mode, 5);
        press(1'b0, 1'b1, 6);
        check("aen_off", alarm_en, 0);
        press(1'b1, 1'b0, 6);
        check("mode_run", mode, 0);
        check("load_still1", load_cnt, 1);

        // Increments in RUN are ignored
        press(1'b0, 1'b1, 6);
        check("run_inc_am", alarm_min, 1);
        check("run_inc_mode", mode, 0);

        // Timeout out of SET_TH with a pending hour edit: no load
        cur_hour = 5'd5;
        cur_min  = 6'd10;
        press(1'b1, 1'b0, 6);
        check("to_enter", mode, 1);
        press(1'b0, 1'b1, 6);
        check("to_th6", time_hour, 6);
        repeat (900) @(negedge clk);
        check("to_not_yet", mode, 1);
        repeat (200) @(negedge clk);
        check("to_run", mode, 0);
        check("to_no_load", load_cnt, 1);

        // Collision inside SET_TH: step only, hour unchanged
        press(1'b1, 1'b0, 6);
        check("col_enter", mode, 1);
        check("col_copy", time_hour, 5);
        press(1'b1, 1'b1, 6);
        check("col_mode", mode, 2);
        check("col_th", time_hour, 5);
        check("col_tm", time_min, 10);

        // Held increment in SET_TM for 20 clk
        press(1'b0, 1'b1, 20);
`ifdef CLKSET_AUTOREPEAT_EN
        check("hold_min", time_min, 17);
`else
        check("hold_min", time_min, 11);
`endif
        check("hold_mode", mode, 2);

        // Asynchronous reset in the middle of SET_TM discards edits
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mode", mode, 0);
        check("arst_tm", time_min, 0);
        check("arst_th", time_hour, 0);
        check("arst_ah", alarm_hour, 7);
        check("arst_am", alarm_min, 30);
        check("arst_aen", alarm_en, 1);
        check("arst_load", time_load, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_load", load_cnt, 1);
        check("arst_mode_hold", mode, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
